// File: rtl/bp_pkg.sv
// Shared types and defaults for the global-history branch predictor controller.
package bp_pkg;

  localparam int         BP_HIST_W   = 8;
  localparam logic [1:0] BP_INIT_CTR = 2'b10;

  typedef enum logic {
    INIT,
    RUN
  } bp_state_e;

  typedef struct packed {
    logic [BP_HIST_W-1:0] idx;
    logic                 pred;
  } bp_entry_t;

endpackage

// File: rtl/bp_inflight_fifo.sv
// In-flight prediction FIFO: synchronous push/pop with a whole-queue flush.
module bp_inflight_fifo
  import bp_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = bp_entry_t
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   push_i,
  input  entry_t push_data_i,
  input  logic   pop_i,
  input  logic   flush_i,
  output entry_t pop_data_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int PW = $clog2(DEPTH);

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [PW:0]     count_q;
  logic            push_ok;
  logic            pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign pop_ok  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a push into a full queue is legal then.
  assign push_ok = push_i && (!full_o || pop_ok);

  assign pop_data_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/branch_predictor_ctrl.sv
// Predictor table sequencer: init sweep, GHR ownership, resolution updates and mispredict flagging.
// Optional BP_PERF_COUNTERS_EN adds branch/mispredict performance counters.
module branch_predictor_ctrl
  import bp_pkg::*;
#(
  parameter int         HIST_W   = BP_HIST_W,
  parameter int         DEPTH    = 4,
  parameter logic [1:0] INIT_CTR = BP_INIT_CTR
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              branch_decode_sig,
  input  logic              prediction_in,
  input  logic              branch_mem_sig,
  input  logic              actual_branch_decision,
  output logic [HIST_W-1:0] ghr,
  output logic              ready,
  output logic              tbl_init_we,
  output logic [HIST_W-1:0] tbl_init_idx,
  output logic              tbl_upd_en,
  output logic [HIST_W-1:0] tbl_upd_idx,
  output logic              tbl_upd_taken,
  output logic              mispredict,
`ifdef BP_PERF_COUNTERS_EN
  output logic [31:0]       perf_branches,
  output logic [31:0]       perf_mispredicts,
`endif
  output logic              err_sticky
);

  typedef struct packed {
    logic [HIST_W-1:0] idx;
    logic              pred;
  } entry_t;

  bp_state_e         state_q;
  logic [HIST_W-1:0] sweep_q;
  logic [HIST_W-1:0] ghr_q;
  logic [HIST_W-1:0] ghr_d;
  logic [HIST_W-1:0] init_idx_q;
  logic [HIST_W-1:0] upd_idx_q;
  logic              ready_q;
  logic              init_we_q;
  logic              upd_en_q;
  logic              upd_taken_q;
  logic              misp_q;
  logic              err_q;

  entry_t            head;
  entry_t            push_entry;
  logic              fifo_full;
  logic              fifo_empty;
  logic              in_run;
  logic              pop_ok;
  logic              flush;
  logic              push_ok;
  logic              err_set;
  logic              unused_init_ctr;

  // The table array owns the init value; it is kept here so the whole predictor is configured in one place.
  assign unused_init_ctr = ^INIT_CTR;

  assign in_run     = (state_q == RUN);
  assign pop_ok     = in_run && branch_mem_sig && !fifo_empty;
  assign flush      = pop_ok && (head.pred != actual_branch_decision);
  assign push_ok    = in_run && branch_decode_sig && !flush;
  assign err_set    = in_run && ((branch_decode_sig && fifo_full && !pop_ok) ||
                                 (branch_mem_sig && fifo_empty));
  assign push_entry = '{idx: ghr_q, pred: prediction_in};
  assign ghr_d      = {ghr_q[HIST_W-2:0], actual_branch_decision};

  bp_inflight_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (push_ok),
    .push_data_i (push_entry),
    .pop_i       (pop_ok),
    .flush_i     (flush),
    .pop_data_o  (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // The GHR advances only on resolution, so it never holds wrong-path history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= INIT;
      sweep_q     <= '0;
      ghr_q       <= '0;
      init_idx_q  <= '0;
      upd_idx_q   <= '0;
      ready_q     <= 1'b0;
      init_we_q   <= 1'b0;
      upd_en_q    <= 1'b0;
      upd_taken_q <= 1'b0;
      misp_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      init_we_q <= 1'b0;
      upd_en_q  <= 1'b0;
      misp_q    <= 1'b0;
      case (state_q)
        INIT: begin
          init_we_q  <= 1'b1;
          init_idx_q <= sweep_q;
          sweep_q    <= sweep_q + 1'b1;
          if (sweep_q == '1) state_q <= RUN;
        end
        RUN: begin
          ready_q <= 1'b1;
          if (pop_ok) begin
            upd_en_q    <= 1'b1;
            upd_idx_q   <= head.idx;
            upd_taken_q <= actual_branch_decision;
            misp_q      <= flush;
            ghr_q       <= ghr_d;
          end
          if (err_set) err_q <= 1'b1;
        end
        default: state_q <= INIT;
      endcase
    end
  end

`ifdef BP_PERF_COUNTERS_EN
  logic [31:0] perf_br_q;
  logic [31:0] perf_mp_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_br_q <= '0;
      perf_mp_q <= '0;
    end else begin
      if (pop_ok) perf_br_q <= perf_br_q + 32'd1;
      if (flush)  perf_mp_q <= perf_mp_q + 32'd1;
    end
  end

  assign perf_branches    = perf_br_q;
  assign perf_mispredicts = perf_mp_q;
`endif

  assign ghr           = ghr_q;
  assign ready         = ready_q;
  assign tbl_init_we   = init_we_q;
  assign tbl_init_idx  = init_idx_q;
  assign tbl_upd_en    = upd_en_q;
  assign tbl_upd_idx   = upd_idx_q;
  assign tbl_upd_taken = upd_taken_q;
  assign mispredict    = misp_q;
  assign err_sticky    = err_q;

endmodule

// File: tb/tb_branch_predictor_ctrl.sv
// Self-checking bench for branch_predictor_ctrl against a queue-based reference model.
module tb_branch_predictor_ctrl;

  localparam int HW    = 8;
  localparam int DEPTH = 4;
  localparam int TBL   = 256;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          dec;
  logic          pred;
  logic          mem;
  logic          act;
  logic [HW-1:0] ghr;
  logic          ready;
  logic          tbl_init_we;
  logic [HW-1:0] tbl_init_idx;
  logic          tbl_upd_en;
  logic [HW-1:0] tbl_upd_idx;
  logic          tbl_upd_taken;
  logic          mispredict;
  logic          err_sticky;
`ifdef BP_PERF_COUNTERS_EN
  logic [31:0]   perf_branches;
  logic [31:0]   perf_mispredicts;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    int idx;
    bit pred;
  } ent_t;

  ent_t mQ[$];
  int   mGhr;
  bit   mErr;
  bit   mUpd;
  bit   mTaken;
  bit   mMisp;
  int   mUpdIdx;
  int   mBr;
  int   mMp;

  branch_predictor_ctrl dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .branch_decode_sig      (dec),
    .prediction_in          (pred),
    .branch_mem_sig         (mem),
    .actual_branch_decision (act),
    .ghr                    (ghr),
    .ready                  (ready),
    .tbl_init_we            (tbl_init_we),
    .tbl_init_idx           (tbl_init_idx),
    .tbl_upd_en             (tbl_upd_en),
    .tbl_upd_idx            (tbl_upd_idx),
    .tbl_upd_taken          (tbl_upd_taken),
    .mispredict             (mispredict),
`ifdef BP_PERF_COUNTERS_EN
    .perf_branches          (perf_branches),
    .perf_mispredicts       (perf_mispredicts),
`endif
    .err_sticky             (err_sticky)
  );

  always #5 clk = ~clk;

  // Every comparison in the bench funnels through here so the counts stay honest.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    mQ.delete();
    mGhr = 0;
    mErr = 0;
    mUpd = 0;
    mMisp = 0;
    mTaken = 0;
    mUpdIdx = 0;
    mBr = 0;
    mMp = 0;
  endtask

  // Reference behaviour of one RUN-mode clock edge, expressed as queue operations.
  task automatic modelStep(input bit d, input bit p, input bit m, input bit a);
    ent_t e;
    bit   flushed;
    int   oldGhr;
    flushed = 0;
    oldGhr  = mGhr;
    mUpd    = 0;
    mMisp   = 0;
    if (m && mQ.size() == 0) mErr = 1;
    if (m && mQ.size() > 0) begin
      e       = mQ.pop_front();
      mUpd    = 1;
      mUpdIdx = e.idx;
      mTaken  = a;
      mMisp   = (e.pred != a);
      mGhr    = (mGhr * 2 + int'(a)) % TBL;
      mBr++;
      if (mMisp) begin
        mMp++;
        mQ.delete();
        flushed = 1;
      end
    end
    if (d && !flushed) begin
      if (mQ.size() < DEPTH) mQ.push_back('{oldGhr, p});
      else mErr = 1;
    end
  endtask

  task automatic compareAll();
    checkOutput("ghr", ghr, mGhr);
    checkOutput("ready", ready, 1);
    checkOutput("init_we_run", tbl_init_we, 0);
    checkOutput("upd_en", tbl_upd_en, mUpd);
    if (mUpd) begin
      checkOutput("upd_idx", tbl_upd_idx, mUpdIdx);
      checkOutput("upd_taken", tbl_upd_taken, mTaken);
    end
    checkOutput("mispredict", mispredict, mMisp);
    checkOutput("err_sticky", err_sticky, mErr);
`ifdef BP_PERF_COUNTERS_EN
    checkOutput("perf_br", perf_branches, mBr);
    checkOutput("perf_mp", perf_mispredicts, mMp);
`endif
  endtask

  // Called at a falling edge: drives one cycle of inputs and checks the result at the next falling edge.
  task automatic applyStimulus(input bit d, input bit p, input bit m, input bit a);
    dec  = d;
    pred = p;
    mem  = m;
    act  = a;
    modelStep(d, p, m, a);
    @(negedge clk);
    compareAll();
  endtask

  task automatic runSweep();
    int nxt;
    int firstReady;
    nxt        = 0;
    firstReady = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tbl_init_we) begin
        checkOutput("init_idx", tbl_init_idx, nxt);
        checkOutput("init_ready_low", ready, 0);
        nxt++;
      end
      if (ready) begin
        firstReady = i;
        break;
      end
    end
    checkOutput("init_count", nxt, TBL);
    checkOutput("ready_cycle", firstReady, TBL);
    checkOutput("init_ghr", ghr, 0);
    checkOutput("init_err", err_sticky, 0);
    checkOutput("init_upd", tbl_upd_en, 0);
  endtask

  task automatic doReset();
    dec     = 0;
    pred    = 0;
    mem     = 0;
    act     = 0;
    reset_n = 0;
    modelReset();
    repeat (2) @(negedge clk);
    checkOutput("rst_init_we", tbl_init_we, 0);
    checkOutput("rst_ready", ready, 0);
    checkOutput("rst_ghr", ghr, 0);
    checkOutput("rst_err", err_sticky, 0);
    reset_n = 1;
    runSweep();
  endtask

  task automatic randomPhase(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(($urandom % 100) < 55, $urandom_range(0, 1),
                    ($urandom % 100) < 45, $urandom_range(0, 1));
    end
    applyStimulus(0, 0, 0, 0);
  endtask

  initial begin
    bit found;

    doReset();

    // Correctly predicted taken branch from ghr 0.
    applyStimulus(1, 1, 0, 0);
    applyStimulus(0, 0, 1, 1);
    checkOutput("cp_upd_en", tbl_upd_en, 1);
    checkOutput("cp_upd_idx", tbl_upd_idx, 8'h00);
    checkOutput("cp_taken", tbl_upd_taken, 1);
    checkOutput("cp_misp", mispredict, 0);
    checkOutput("cp_ghr", ghr, 8'h01);
    applyStimulus(0, 0, 0, 0);

    randomPhase(400);

    // Asynchronous reset while running clears state without waiting for a clock.
    #1 reset_n = 0;
    #1;
    checkOutput("arst_ghr", ghr, 0);
    checkOutput("arst_err", err_sticky, 0);
    checkOutput("arst_ready", ready, 0);
    checkOutput("arst_upd", tbl_upd_en, 0);
    checkOutput("arst_misp", mispredict, 0);
    modelReset();
    @(negedge clk);
    reset_n = 1;

    // Reset again in the middle of the sweep, at index 100.
    found = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tbl_init_we && tbl_init_idx == 8'd100) begin
        found = 1;
        break;
      end
    end
    checkOutput("mid_found", found, 1);
    #1 reset_n = 0;
    #1;
    checkOutput("mid_init_we", tbl_init_we, 0);
    checkOutput("mid_ready", ready, 0);
    checkOutput("mid_ghr", ghr, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1;
    runSweep();

    // Mispredict discards the younger in-flight entries.
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 1, 0);
    checkOutput("mp_flag", mispredict, 1);
    checkOutput("mp_err_before", err_sticky, 0);
    applyStimulus(0, 0, 1, 1);
    checkOutput("mp_empty_err", err_sticky, 1);
    checkOutput("mp_noshift", ghr, 0);
    checkOutput("mp_noupd", tbl_upd_en, 0);

    // Full queue: simultaneous push/pop is fine, lone push overflows.
    doReset();
    repeat (DEPTH) applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 1, 1);
    checkOutput("full_pp_err", err_sticky, 0);
    checkOutput("full_pp_upd", tbl_upd_en, 1);
    applyStimulus(1, 1, 0, 0);
    checkOutput("full_push_err", err_sticky, 1);
    repeat (DEPTH) applyStimulus(0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0);

`ifdef BP_PERF_COUNTERS_EN
    doReset();
    repeat (3) begin
      applyStimulus(1, 1, 0, 0);
      applyStimulus(0, 0, 1, 1);
    end
    repeat (2) begin
      applyStimulus(1, 1, 0, 0);
      applyStimulus(0, 0, 1, 0);
    end
    checkOutput("perf_br5", perf_branches, 5);
    checkOutput("perf_mp2", perf_mispredicts, 2);
`endif

    doReset();
    randomPhase(300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
